mult_acc_stage: RTL and testbench
=================================

Name: mult_acc_stage

Overview:
- Downstream consumer of the 3-bit shift-add multiplier (FSM + datapath pair).
- Captures each finished product R and sums COUNT consecutive products into a dot-product result.
- Presents each result on a valid/ready output port.
- Back-pressures the multiplier controller through prod_ready while a result waits to be taken.

Parameters:
- WIDTH, 3: multiplier operand width; the product bus is 2*WIDTH bits.
- ACC_WIDTH, 10: accumulator and result width; must be at least 2*WIDTH.
- COUNT, 4: number of products summed per result; must be 2 or more.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (the reset port is named reset, as elsewhere in the codebase; asserted when 0).
- prod_valid  input  1  one-cycle pulse from the multiplier controller: prod holds a finished product.
- prod  input  2*WIDTH  product value (R).
- prod_ready  output  1  stage can accept a product this cycle.
- acc_out  output  ACC_WIDTH  accumulated result.
- out_valid  output  1  acc_out holds a complete result.
- out_ready  input  1  consumer accepts the result.
- overflow  output  1  the result saturated; valid together with out_valid.
- dropped  output  1  sticky flag: a product arrived while prod_ready was 0.
- prod_count  output  clog2(COUNT+1)  number of products accepted into the current sum.

Behaviour:
- Reset (reset==0 at a rising edge) clears the following:
  - acc_out=0, out_valid=0, overflow=0, dropped=0, prod_count=0.
  - State goes to ACCUM, so prod_ready=1 in the next cycle.
  - Reset takes priority over every other event and aborts any partial sum or pending result.
- State ACCUM (prod_ready=1):
  - A product is accepted on any edge where prod_valid=1.
  - sum = acc_out + zero-extended prod, computed at ACC_WIDTH+1 bits.
  - If sum > 2^ACC_WIDTH-1: acc_out becomes 2^ACC_WIDTH-1 and an internal sat bit is set. Otherwise acc_out becomes sum.
  - Once sat is set, acc_out stays at the maximum for the rest of the group.
  - prod_count increments by 1.
  - On the COUNT-th accept: go to HOLD; out_valid=1 and overflow=sat in the following cycle, which is 1-cycle latency from the last accept.
- State HOLD (prod_ready=0):
  - acc_out, overflow and prod_count=COUNT are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_valid=1 and out_ready=1 (handshake): next cycle out_valid=0, overflow=0, acc_out=0, prod_count=0, sat=0, state goes to ACCUM.
  - No product is accepted on the handshake edge.
  - out_ready is ignored when out_valid=0.
- prod_valid=1 while prod_ready=0:
  - The product is discarded and dropped is set.
  - dropped stays 1 until reset; it is not cleared by a handshake.
- Width rules:
  - Products are unsigned and zero-extended to ACC_WIDTH.
  - No truncation occurs except through saturation.
  - acc_out never wraps.
- Back-to-back products (prod_valid high on consecutive cycles) are each accepted in ACCUM; there is no required gap.
- All outputs are registered; prod_ready is decoded from the state register only.

Test Plan:
- Reset, then 4 products 6,7,12,49 with idle gaps -> out_valid rises the cycle after the 4th accept; acc_out=74, overflow=0, prod_count=4, prod_ready=0.
- Hold out_ready=0 for 5 cycles, then pulse it high -> acc_out stays 74 throughout; out_valid drops 1 cycle after the handshake; acc_out=0, prod_count=0, prod_ready=1.
- ACC_WIDTH=7, products 49,49,49,49 -> after the 3rd accept acc_out=127 (saturated); final acc_out=127, overflow=1. The next group of 1,1,1,1 gives acc_out=4, overflow=0.
- In HOLD, pulse prod_valid with prod=9 -> product ignored; acc_out unchanged; dropped=1 and still 1 after the handshake and after the next group completes.
- Accept 2 products (5,5), then reset=0 for one edge -> acc_out=0, prod_count=0, dropped=0, out_valid=0. The next 4 products 1,2,3,4 give acc_out=10.
- 4 products on consecutive cycles (3,3,3,3) -> all accepted; out_valid high on cycle 5 with acc_out=12.

Source files
------------

// File: rtl/mult_acc_stage.sv
// mult_acc_stage: sums COUNT consecutive products from the shift-add multiplier
// into a saturating dot-product result. The result is offered on a valid/ready
// port, and prod_ready holds the multiplier off while that result is waiting.
module mult_acc_stage #(
    parameter int WIDTH     = 3,
    parameter int ACC_WIDTH = 10,
    parameter int COUNT     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         prod_valid,
    input  logic [2*WIDTH-1:0]           prod,
    output logic                         prod_ready,
    output logic [ACC_WIDTH-1:0]         acc_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overflow,
    output logic                         dropped,
    output logic [$clog2(COUNT+1)-1:0]   prod_count
);

    localparam int                   CW      = $clog2(COUNT + 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
    localparam logic [CW-1:0]        LAST    = CW'(COUNT - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t               state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 sat_q;
    logic                 sat_d;
    logic [CW-1:0]        cnt_q;
    logic                 valid_q;
    logic                 ovf_q;
    logic                 drop_q;
    logic [ACC_WIDTH:0]   sum;

    // The sum is formed one bit wider than the accumulator so the carry-out
    // flags saturation. Once a group has saturated, it stays pinned at the maximum.
    always_comb begin
        sum   = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod);
        sat_d = sat_q | sum[ACC_WIDTH];
        acc_d = sat_d ? ACC_MAX : sum[ACC_WIDTH-1:0];
    end

    // Control FSM and output registers: collect products in ACCUM, then present
    // the result in HOLD until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (prod_valid) begin
                        acc_q <= acc_d;
                        sat_q <= sat_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                            ovf_q   <= sat_d;
                        end
                    end
                end
                HOLD: begin
                    if (prod_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (valid_q && out_ready) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        cnt_q   <= '0;
                        valid_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    assign prod_ready = (state_q == ACCUM);
    assign acc_out    = acc_q;
    assign out_valid  = valid_q;
    assign overflow   = ovf_q;
    assign dropped    = drop_q;
    assign prod_count = cnt_q;

endmodule

// File: tb/tb_mult_acc_stage.sv
// tb_mult_acc_stage: drives the accumulation stage with directed and random
// products and checks every output against a behavioural model that works on
// plain integer sums.
module tb_mult_acc_stage;

    localparam int MAXM = 1023;
    localparam int MAXS = 127;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       prod_valid = 1'b0;
    logic [5:0] prod = '0;
    logic       out_ready = 1'b0;
    logic       prod_ready;
    logic [9:0] acc_out;
    logic       out_valid;
    logic       overflow;
    logic       dropped;
    logic [2:0] prod_count;

    logic       sPv = 1'b0;
    logic [5:0] sProd = '0;
    logic       sOutReady = 1'b0;
    logic       sProdReady;
    logic [6:0] sAcc;
    logic       sOutValid;
    logic       sOverflow;
    logic       sDropped;
    logic [2:0] sCount;

    int passCount = 0;
    int checkCount = 0;

    int mCount, mSum;
    bit mHold, mDropped;
    int smCount, smSum;
    bit smHold;

    mult_acc_stage #(.WIDTH(3), .ACC_WIDTH(10), .COUNT(4)) dut (
        .clk(clk), .reset(reset), .prod_valid(prod_valid), .prod(prod),
        .prod_ready(prod_ready), .acc_out(acc_out), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow), .dropped(dropped),
        .prod_count(prod_count)
    );

    mult_acc_stage #(.WIDTH(3), .ACC_WIDTH(7), .COUNT(4)) satDut (
        .clk(clk), .reset(reset), .prod_valid(sPv), .prod(sProd),
        .prod_ready(sProdReady), .acc_out(sAcc), .out_valid(sOutValid),
        .out_ready(sOutReady), .overflow(sOverflow), .dropped(sDropped),
        .prod_count(sCount)
    );

    always #5 clk = ~clk;

    function automatic int expAcc();
        return (mSum > MAXM) ? MAXM : mSum;
    endfunction

    function automatic int expSatAcc();
        return (smSum > MAXS) ? MAXS : smSum;
    endfunction

    // One clock on the main stage; the model follows what the stage should do at that edge.
    task automatic stepMain(input bit pv, input int p, input bit rdy);
        prod_valid = pv;
        prod       = 6'(p);
        out_ready  = rdy;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod       = '0;
        out_ready  = 1'b0;
        if (!mHold) begin
            if (pv) begin
                mCount++;
                mSum += p;
                if (mCount == 4) mHold = 1'b1;
            end
        end else begin
            if (pv) mDropped = 1'b1;
            if (rdy) begin
                mHold  = 1'b0;
                mCount = 0;
                mSum   = 0;
            end
        end
    endtask

    task automatic stepSat(input bit pv, input int p, input bit rdy);
        sPv       = pv;
        sProd     = 6'(p);
        sOutReady = rdy;
        @(posedge clk);
        #1;
        sPv       = 1'b0;
        sProd     = '0;
        sOutReady = 1'b0;
        if (!smHold) begin
            if (pv) begin
                smCount++;
                smSum += p;
                if (smCount == 4) smHold = 1'b1;
            end
        end else if (rdy) begin
            smHold  = 1'b0;
            smCount = 0;
            smSum   = 0;
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        mCount   = 0;
        mSum     = 0;
        mHold    = 1'b0;
        mDropped = 1'b0;
        smCount  = 0;
        smSum    = 0;
        smHold   = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        doReset();
        checkCount++; if (acc_out !== 10'd0) $display("[TB] FAIL reset_acc got %0d want 0", acc_out); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", out_valid); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf got %b want 0", overflow); else passCount++;
        checkCount++; if (dropped !== 1'b0) $display("[TB] FAIL reset_dropped got %b want 0", dropped); else passCount++;
        checkCount++; if (prod_count !== 3'd0) $display("[TB] FAIL reset_count got %0d want 0", prod_count); else passCount++;
        checkCount++; if (prod_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", prod_ready); else passCount++;
    endtask

    task automatic test_group();
        stepMain(1, 6, 0);  stepMain(0, 0, 0);
        stepMain(1, 7, 0);  stepMain(0, 0, 0);
        stepMain(1, 12, 0); stepMain(0, 0, 0);
        checkCount++; if (acc_out !== 10'd25) $display("[TB] FAIL group_partial_acc got %0d want 25", acc_out); else passCount++;
        checkCount++; if (prod_count !== 3'd3) $display("[TB] FAIL group_partial_count got %0d want 3", prod_count); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL group_early_valid got %b want 0", out_valid); else passCount++;
        stepMain(1, 49, 0);
        checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL group_valid got %b want 1", out_valid); else passCount++;
        checkCount++; if (acc_out !== 10'd74) $display("[TB] FAIL group_acc got %0d want 74", acc_out); else passCount++;
        checkCount++; if (int'(acc_out) !== expAcc()) $display("[TB] FAIL group_model_acc got %0d want %0d", acc_out, expAcc()); else passCount++;
        checkCount++; if (overflow !== 1'b0) $display("[TB] FAIL group_ovf got %b want 0", overflow); else passCount++;
        checkCount++; if (prod_count !== 3'd4) $display("[TB] FAIL group_count got %0d want 4", prod_count); else passCount++;
        checkCount++; if (prod_ready !== 1'b0) $display("[TB] FAIL group_ready got %b want 0", prod_ready); else passCount++;
    endtask

    task automatic test_hold_handshake();
        for (int i = 0; i < 5; i++) begin
            stepMain(0, 0, 0);
            checkCount++; if (acc_out !== 10'd74 || out_valid !== 1'b1) $display("[TB] FAIL hold_stable cycle %0d got acc %0d valid %b want 74/1", i, acc_out, out_valid); else passCount++;
        end
        stepMain(0, 0, 1);
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL hs_valid got %b want 0", out_valid); else passCount++;
        checkCount++; if (acc_out !== 10'd0) $display("[TB] FAIL hs_acc got %0d want 0", acc_out); else passCount++;
        checkCount++; if (prod_count !== 3'd0) $display("[TB] FAIL hs_count got %0d want 0", prod_count); else passCount++;
        checkCount++; if (prod_ready !== 1'b1) $display("[TB] FAIL hs_ready got %b want 1", prod_ready); else passCount++;
    endtask

    task automatic test_drop();
        int heldAcc;
        for (int i = 0; i < 4; i++) stepMain(1, $urandom_range(0, 63), 0);
        heldAcc = expAcc();
        stepMain(1, 9, 0);
        checkCount++; if (int'(acc_out) !== heldAcc) $display("[TB] FAIL drop_acc got %0d want %0d", acc_out, heldAcc); else passCount++;
        checkCount++; if (dropped !== 1'b1) $display("[TB] FAIL drop_flag got %b want 1", dropped); else passCount++;
        checkCount++; if (prod_count !== 3'd4) $display("[TB] FAIL drop_count got %0d want 4", prod_count); else passCount++;
        stepMain(0, 0, 1);
        checkCount++; if (dropped !== 1'b1) $display("[TB] FAIL drop_after_hs got %b want 1", dropped); else passCount++;
        for (int i = 0; i < 4; i++) stepMain(1, $urandom_range(0, 63), 0);
        checkCount++; if (dropped !== 1'b1) $display("[TB] FAIL drop_after_group got %b want 1", dropped); else passCount++;
        checkCount++; if (int'(acc_out) !== expAcc() || out_valid !== 1'b1) $display("[TB] FAIL drop_group_acc got %0d/%b want %0d/1", acc_out, out_valid, expAcc()); else passCount++;
        stepMain(0, 0, 1);
    endtask

    task automatic test_reset_mid();
        stepMain(1, 5, 0);
        stepMain(1, 5, 0);
        checkCount++; if (acc_out !== 10'd10 || prod_count !== 3'd2) $display("[TB] FAIL mid_partial got %0d/%0d want 10/2", acc_out, prod_count); else passCount++;
        doReset();
        checkCount++; if (acc_out !== 10'd0) $display("[TB] FAIL mid_acc got %0d want 0", acc_out); else passCount++;
        checkCount++; if (prod_count !== 3'd0) $display("[TB] FAIL mid_count got %0d want 0", prod_count); else passCount++;
        checkCount++; if (dropped !== 1'b0) $display("[TB] FAIL mid_dropped got %b want 0", dropped); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_valid got %b want 0", out_valid); else passCount++;
        for (int i = 1; i <= 4; i++) stepMain(1, i, 0);
        checkCount++; if (acc_out !== 10'd10 || out_valid !== 1'b1) $display("[TB] FAIL mid_next_group got %0d/%b want 10/1", acc_out, out_valid); else passCount++;
        stepMain(0, 0, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            stepMain(1, 3, 0);
            checkCount++; if (int'(prod_count) !== i + 1) $display("[TB] FAIL b2b_count step %0d got %0d want %0d", i, prod_count, i + 1); else passCount++;
        end
        checkCount++; if (out_valid !== 1'b1 || acc_out !== 10'd12) $display("[TB] FAIL b2b_result got %0d/%b want 12/1", acc_out, out_valid); else passCount++;
        stepMain(0, 0, 1);
    endtask

    task automatic test_random();
        bit pv, rdy;
        int p;
        for (int i = 0; i < 300; i++) begin
            pv  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) == 0);
            p   = $urandom_range(0, 63);
            stepMain(pv, p, rdy);
            checkCount++;
            if (int'(acc_out) !== expAcc() || out_valid !== mHold || overflow !== (mHold && mSum > MAXM)
                || int'(prod_count) !== mCount || prod_ready !== !mHold || dropped !== mDropped)
                $display("[TB] FAIL rand cycle %0d got acc %0d v %b o %b c %0d r %b d %b want acc %0d v %b c %0d d %b",
                         i, acc_out, out_valid, overflow, prod_count, prod_ready, dropped, expAcc(), mHold, mCount, mDropped);
            else passCount++;
        end
    endtask

    task automatic test_saturate();
        stepSat(1, 49, 0); stepSat(1, 49, 0); stepSat(1, 49, 0);
        checkCount++; if (sAcc !== 7'd127) $display("[TB] FAIL sat_third_acc got %0d want 127", sAcc); else passCount++;
        checkCount++; if (sOutValid !== 1'b0) $display("[TB] FAIL sat_third_valid got %b want 0", sOutValid); else passCount++;
        stepSat(1, 49, 0);
        checkCount++; if (sAcc !== 7'd127 || sOverflow !== 1'b1 || sOutValid !== 1'b1) $display("[TB] FAIL sat_final got %0d/%b/%b want 127/1/1", sAcc, sOverflow, sOutValid); else passCount++;
        stepSat(0, 0, 1);
        checkCount++; if (sAcc !== 7'd0 || sOverflow !== 1'b0) $display("[TB] FAIL sat_clear got %0d/%b want 0/0", sAcc, sOverflow); else passCount++;
        for (int i = 0; i < 4; i++) stepSat(1, 1, 0);
        checkCount++; if (sAcc !== 7'd4 || sOverflow !== 1'b0 || sOutValid !== 1'b1) $display("[TB] FAIL sat_small got %0d/%b/%b want 4/0/1", sAcc, sOverflow, sOutValid); else passCount++;
        stepSat(0, 0, 1);
        for (int g = 0; g < 12; g++) begin
            for (int i = 0; i < 4; i++) begin
                stepSat(1, $urandom_range(0, 63), 0);
                checkCount++; if (int'(sAcc) !== expSatAcc()) $display("[TB] FAIL sat_rand_acc group %0d step %0d got %0d want %0d", g, i, sAcc, expSatAcc()); else passCount++;
            end
            checkCount++; if (sOverflow !== (smSum > MAXS) || sOutValid !== 1'b1) $display("[TB] FAIL sat_rand_ovf group %0d got %b/%b want %b/1", g, sOverflow, sOutValid, smSum > MAXS); else passCount++;
            stepSat(0, 0, 1);
        end
    endtask

    initial begin
        test_reset();
        test_group();
        test_hold_handshake();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
